// File: rtl/qlf_k6n10_pipelined_adder.sv
// Pipelined add/subtract unit for the QLF K6N10 fabric.
// The operand is cut into carry-chain segments of at most SEG bits. Each
// stage adds one segment and registers its carry-out into the next stage.
// Operand bits not yet consumed ride along with the beat (skew). Result bits
// already produced are carried forward to the last stage (deskew), so every
// result leaves as one aligned word.
module qlf_k6n10_pipelined_adder #(
   parameter int WIDTH  = 48,
   parameter int SEG    = 20,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             co,
   output logic             ovf
);

   localparam int S = (WIDTH + SEG - 1) / SEG;

   // The whole pipeline advances as one unit; it stalls only while a
   // finished result waits for the downstream consumer.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int LO = k * SEG;
      localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;
      localparam int N  = HI - LO;

      logic              v_in;
      logic              c_in;
      logic [WIDTH-1:LO] a_in;
      logic [WIDTH-1:LO] b_in;
      logic [N:0]        sum;
      logic [HI-1:0]     res_d;
      logic              v_q;
      logic              c_q;
      logic [HI-1:0]     res_q;

      if (k == 0) begin : g_head
         assign v_in  = in_valid;
         assign c_in  = ci;
         assign a_in  = a;
         assign b_in  = sub ? ~b : b;
         assign res_d = sum[N-1:0];
      end else begin : g_body
         assign v_in  = g_stage[k-1].v_q;
         assign c_in  = g_stage[k-1].c_q;
         assign a_in  = g_stage[k-1].g_fwd.a_q;
         assign b_in  = g_stage[k-1].g_fwd.b_q;
         assign res_d = {sum[N-1:0], g_stage[k-1].res_q};
      end

      // One carry-chain segment: at most SEG adder cells.
      assign sum = {1'b0, a_in[HI-1:LO]} + {1'b0, b_in[HI-1:LO]} + {{N{1'b0}}, c_in};

      // Stage valid, segment carry-out and result bits produced so far.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            res_q <= '0;
         end else if (adv) begin
            v_q   <= v_in;
            c_q   <= sum[N];
            res_q <= res_d;
         end
      end

      if (HI < WIDTH) begin : g_fwd
         logic [WIDTH-1:HI] a_q;
         logic [WIDTH-1:HI] b_q;

         // Operand bits of the later segments wait one more stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_in[WIDTH-1:HI];
               b_q <= b_in[WIDTH-1:HI];
            end
         end
      end else begin : g_last
         logic ovf_d;
         logic ovf_q;

         if (SIGNED != 0) begin : g_ovf
            assign ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[N-1] != a_in[WIDTH-1]);
         end else begin : g_no_ovf
            assign ovf_d = 1'b0;
         end

         // Signed overflow is known only once the top segment is summed.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= ovf_d;
            end
         end

         // Result outputs are forced to zero whenever no beat is presented.
         assign out_valid = v_q;
         assign y         = v_q ? res_q : '0;
         assign co        = v_q & c_q;
         assign ovf       = v_q & ovf_q;
      end
   end

endmodule
